pal_cfg_loader: RTL and testbench
=================================

# pal_cfg_loader

Hardware configuration controller that programs the PAL fabric's serial configuration chain from a byte-wide bitstream source. It accepts bytes over a valid/ready handshake, serializes them LSB-first, and drives the PAL's configuration clock and data pins so that bit index i of the bitstream is the i-th bit shifted in. It sits between the on-chip bitstream source (ROM, UART, or host bus) and the PAL's CLK/CFG pins, and replaces the manual pulse sequencing previously done from simulation.

## Interface
Parameters:
- N, 4, number of PAL input variables
- M, 1, number of PAL outputs
- P, 3, number of intermediate product stages
- Derived, not overridable: LEN = 2*N*P + P*M bits (27 at defaults); NBYTES = ceil(LEN/8) (4 at defaults)

Ports:
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  one-cycle request to begin programming; sampled only in IDLE
- DIN  in  8  bitstream byte; bit 0 is shifted first
- DIN_VALID  in  1  DIN holds a valid byte
- DIN_READY  out  1  loader accepts DIN this cycle
- PAL_CLK  out  1  configuration clock to the PAL CLK pin; registered
- PAL_CFG  out  1  configuration data to the PAL CFG pin; registered
- BUSY  out  1  high in every state except IDLE and DONE
- DONE  out  1  high once all LEN bits are shifted; held until the next START or RST
- ERR  out  1  checksum mismatch flag (see Configuration)

## Operation
- States: IDLE, FETCH, SETUP, HIGH, DONE.
- IDLE: START=1 -> FETCH; clears bit counter (0..LEN-1) and ERR.
- FETCH: DIN_READY=1. On DIN_VALID & DIN_READY, load DIN into the shift register and go to SETUP. No timeout.
- SETUP: PAL_CFG <= shift[0]; PAL_CLK <= 0; go to HIGH.
- HIGH: PAL_CLK <= 1; PAL_CFG holds. Shift the register right and increment the bit counter. Then:
  - If the counter reaches LEN: go to DONE.
  - Else if 8 bits of the current byte are consumed: go to FETCH.
  - Else: go to SETUP.
- DONE: PAL_CLK <= 0; DONE=1. START=1 -> FETCH (reprogramming; DONE drops).
- Last byte: only bits 0..(LEN-1)%8 are shifted. Upper bits are ignored, and no extra byte is requested.
- START outside IDLE/DONE is ignored. DIN_VALID outside FETCH is ignored, so the source must hold the byte.
- Exactly LEN rising edges on PAL_CLK per programming run.

## Timing
- Reset values: DIN_READY=0, PAL_CLK=0, PAL_CFG=0, BUSY=0, DONE=0, ERR=0, state IDLE.
- Bit cell: 2 CLK cycles. PAL_CFG changes only when entering SETUP, one cycle before the PAL_CLK rising edge. It stays stable through the PAL_CLK high cycle and the following low cycle, giving one cycle of setup and at least one cycle of hold.
- PAL_CLK high is exactly one CLK cycle. Low time is at least one cycle, plus one cycle per FETCH.
- Per-byte cost with DIN_VALID held high: 1 fetch cycle + 2 cycles per bit.
- Defaults (LEN=27), VALID always high: DONE rises on the 59th rising edge after the edge that samples START.
- RST mid-run: on the next edge, PAL_CLK and PAL_CFG are forced low and the state returns to IDLE. The PAL is left partially programmed, and software must issue START again. No glitch on PAL_CLK: it is only ever driven from a register.
- RST and START in the same cycle: RST wins.

## Configuration
- Macro: PAL_CFG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data bit, HIGH goes to FETCH once more to accept a checksum byte.
  - The checksum byte must equal the XOR of all NBYTES data bytes as delivered, including ignored upper bits.
  - On acceptance, go to DONE. ERR=1 on mismatch, else 0; ERR is held with DONE.
  - Adds one cycle at VALID-always (60 edges at defaults).
- Undefined: no checksum byte is requested, and ERR is tied to 0.

## Test plan
- Default-parameter bitstream: bytes 0x04, 0x41, 0x10, 0x04 with DIN_VALID held high, START pulse.
  - PAL_CFG sampled on the 27 PAL_CLK rising edges gives 1 at indices 2, 8, 14, 20, 26 and 0 elsewhere.
  - DONE on edge 59.
  - Exactly 4 handshakes.
- Throttled source: DIN_VALID deasserted for 5 cycles before each byte.
  - Same 27-bit sequence.
  - PAL_CLK stays low while stalled.
  - DONE on edge 79.
- RST asserted during bit 12's HIGH cycle.
  - Next edge: PAL_CLK=0, BUSY=0, DONE=0.
  - A subsequent START reprograms from bit 0 with the full 27 pulses.
- START pulsed repeatedly during BUSY.
  - Ignored: pulse count stays 27 and no extra handshakes occur.
  - START in DONE begins a second full run.
- With PAL_CFG_LOADER_CHECKSUM_EN:
  - Checksum 0x51 gives DONE=1, ERR=0.
  - Checksum 0x50 gives DONE=1, ERR=1.
  - DONE on edge 60 in both cases.
- Non-default parameters N=8, M=2, P=4 (LEN=72, 9 bytes), bytes 0x00..0x08.
  - 72 pulses.
  - Serialized stream matches the bytes LSB-first.
  - DONE on edge 1 + 9*17 = 154.

Source files
------------

// File: rtl/pal_cfg_loader.sv
// Serial configuration loader for the PAL fabric: byte-wide bitstream in, LSB-first CLK/CFG pulses out.
// Optional macro PAL_CFG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and drives ERR.
//
// state   | meaning
// IDLE    | waiting for START after reset
// FETCH   | DIN_READY high, waiting for the next byte
// SETUP   | present next bit on PAL_CFG with PAL_CLK low
// HIGH    | raise PAL_CLK, consume the bit
// DONE    | all bits shifted, DONE held until START
module pal_cfg_loader #(
    parameter int N = 4,
    parameter int M = 1,
    parameter int P = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic       PAL_CLK,
    output logic       PAL_CFG,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);
    localparam int LEN = 2 * N * P + P * M;
    localparam int CW = ($clog2(LEN + 1) < 3) ? 3 : $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_HIGH,
        S_DONE
    } state_t;

    state_t state, state_nxt;
    logic [7:0]    shift;
    logic [CW-1:0] bit_cnt;
    logic          pal_clk, pal_cfg, busy, done;
    logic          take, last_bit, restart;

    assign DIN_READY = (state == S_FETCH);
    assign take      = DIN_READY && DIN_VALID;
    assign last_bit  = (bit_cnt == LAST);
    assign restart   = ((state == S_IDLE) || (state == S_DONE)) && START;

`ifdef PAL_CFG_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
    logic       chk_phase;
    logic [7:0] csum;
    logic       err;

    // Checksum covers every delivered data byte, including bits never shifted out.
    always_ff @(posedge CLK) begin
        if (RST) begin
            chk_phase <= 1'b0;
            csum      <= '0;
            err       <= 1'b0;
        end else if (restart) begin
            chk_phase <= 1'b0;
            csum      <= '0;
            err       <= 1'b0;
        end else if (state == S_HIGH && last_bit) begin
            chk_phase <= 1'b1;
        end else if (take) begin
            if (chk_phase) err <= (DIN != csum);
            else csum <= csum ^ DIN;
        end
    end
    assign ERR = err;
`else
    localparam bit CHK_EN = 1'b0;
    logic chk_phase;
    assign chk_phase = 1'b0;
    assign ERR       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_FETCH;
            S_FETCH: if (DIN_VALID) state_nxt = chk_phase ? S_DONE : S_SETUP;
            S_SETUP: state_nxt = S_HIGH;
            S_HIGH: begin
                if (last_bit) state_nxt = CHK_EN ? S_FETCH : S_DONE;
                else if (bit_cnt[2:0] == 3'd7) state_nxt = S_FETCH;
                else state_nxt = S_SETUP;
            end
            S_DONE:  if (START) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the current state so PAL_CLK can never glitch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            pal_clk <= 1'b0;
            pal_cfg <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pal_clk <= (state == S_HIGH);
            busy    <= (state != S_IDLE) && (state != S_DONE);
            done    <= (state == S_DONE) && !START;
            if (restart) bit_cnt <= '0;
            if (take && !chk_phase) shift <= DIN;
            if (state == S_SETUP) pal_cfg <= shift[0];
            if (state == S_HIGH) begin
                shift   <= shift >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign PAL_CLK = pal_clk;
    assign PAL_CFG = pal_cfg;
    assign BUSY    = busy;
    assign DONE    = done;
endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader: default and N=8/M=2/P=4 instances, shared stimulus, selectable monitor.
`timescale 1ns/1ps
module tb_pal_cfg_loader;
`ifdef PAL_CFG_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam logic [127:0] EXP_A = 128'h4104104;
    localparam logic [127:0] EXP_B = 128'h080706050403020100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start_req = 1'b0;
    logic       sel_b = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       start_a, start_b;
    logic       ready_a, pal_clk_a, pal_cfg_a, busy_a, done_a, err_a;
    logic       ready_b, pal_clk_b, pal_cfg_b, busy_b, done_b, err_b;
    logic       din_ready, pal_clk, pal_cfg, busy, done, err;

    assign start_a   = start_req & ~sel_b;
    assign start_b   = start_req & sel_b;
    assign din_ready = sel_b ? ready_b : ready_a;
    assign pal_clk   = sel_b ? pal_clk_b : pal_clk_a;
    assign pal_cfg   = sel_b ? pal_cfg_b : pal_cfg_a;
    assign busy      = sel_b ? busy_b : busy_a;
    assign done      = sel_b ? done_b : done_a;
    assign err       = sel_b ? err_b : err_a;

    pal_cfg_loader dut_a (
        .CLK(clk), .RST(rst), .START(start_a), .DIN(din), .DIN_VALID(din_valid),
        .DIN_READY(ready_a), .PAL_CLK(pal_clk_a), .PAL_CFG(pal_cfg_a),
        .BUSY(busy_a), .DONE(done_a), .ERR(err_a)
    );

    pal_cfg_loader #(.N(8), .M(2), .P(4)) dut_b (
        .CLK(clk), .RST(rst), .START(start_b), .DIN(din), .DIN_VALID(din_valid),
        .DIN_READY(ready_b), .PAL_CLK(pal_clk_b), .PAL_CFG(pal_cfg_b),
        .BUSY(busy_b), .DONE(done_b), .ERR(err_b)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] src[$];
    int src_idx, stall, throttle;
    int edge_no, rises, hs_cnt, done_edge, stall_high;
    logic [127:0] cap_vec;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: record handshake / PAL_CLK rise across the edge, then drive the source.
    task automatic tick();
        logic hs, stalled, clk_prev;
        hs       = din_valid && din_ready;
        stalled  = din_ready && !din_valid;
        clk_prev = pal_clk;
        @(posedge clk);
        #1;
        edge_no++;
        if (hs) begin
            hs_cnt++;
            src_idx++;
            stall = throttle;
        end else if (stalled && stall > 0) begin
            stall--;
        end
        if (stalled && pal_clk) stall_high++;
        if (!clk_prev && pal_clk) begin
            if (rises < 128) cap_vec[rises] = pal_cfg;
            rises++;
        end
        if (done && done_edge < 0) done_edge = edge_no;
        if (src_idx < src.size()) begin
            din       = src[src_idx];
            din_valid = (stall == 0);
        end else begin
            din       = 8'h00;
            din_valid = 1'b0;
        end
    endtask

    task automatic load_default(input logic [7:0] cs);
        src = {8'h04, 8'h41, 8'h10, 8'h04};
        if (CS != 0) src.push_back(cs);
    endtask

    task automatic run_prog(input int thr, input bit poke, input int rst_edge, input int max_edges);
        throttle   = thr;
        stall      = thr;
        src_idx    = 0;
        rises      = 0;
        hs_cnt     = 0;
        done_edge  = -1;
        stall_high = 0;
        cap_vec    = '0;
        din        = src[0];
        din_valid  = (stall == 0);
        start_req  = 1'b1;
        edge_no    = -1;
        tick();
        start_req = 1'b0;
        while (done_edge < 0 && edge_no < max_edges) begin
            if (edge_no == rst_edge) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_pal_clk", 128'(pal_clk), 128'(0));
                check("rst_busy", 128'(busy), 128'(0));
                check("rst_done", 128'(done), 128'(0));
                check("rst_rises", 128'(rises), 128'(12));
                return;
            end
            if (poke && (edge_no == 9 || edge_no == 29 || edge_no == 49)) start_req = 1'b1;
            tick();
            start_req = 1'b0;
        end
        repeat (4) tick();
    endtask

    task automatic check_run(input string tag, input int exp_rises, input int exp_done,
                             input int exp_hs, input logic [127:0] exp_stream, input logic exp_err);
        check({tag, "_rises"}, 128'(rises), 128'(exp_rises));
        check({tag, "_done_edge"}, 128'(done_edge), 128'(exp_done));
        check({tag, "_handshakes"}, 128'(hs_cnt), 128'(exp_hs));
        check({tag, "_stream"}, cap_vec, exp_stream);
        check({tag, "_done_held"}, 128'(done), 128'(1));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_err"}, 128'(err), 128'(exp_err));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        src = {8'h00};
        throttle = 0;
        stall = 0;
        repeat (3) tick();
        check("reset_ready", 128'(ready_a), 128'(0));
        check("reset_pal_clk", 128'(pal_clk_a), 128'(0));
        check("reset_pal_cfg", 128'(pal_cfg_a), 128'(0));
        check("reset_busy", 128'(busy_a), 128'(0));
        check("reset_done", 128'(done_a), 128'(0));
        check("reset_err", 128'(err_a), 128'(0));
        rst = 1'b0;
        tick();

        load_default(8'h51);
        run_prog(0, 1'b0, -1, 400);
        check_run("basic", 27, 59 + CS, 4 + CS, EXP_A, 1'b0);

        load_default(8'h51);
        run_prog(5, 1'b0, -1, 400);
        check_run("throttle", 27, 79 + 6 * CS, 4 + CS, EXP_A, 1'b0);
        check("throttle_clk_low", 128'(stall_high), 128'(0));

        load_default(8'h51);
        run_prog(0, 1'b1, -1, 400);
        check_run("start_poke", 27, 59 + CS, 4 + CS, EXP_A, 1'b0);

        load_default(8'h51);
        run_prog(0, 1'b0, -1, 400);
        check_run("rerun_from_done", 27, 59 + CS, 4 + CS, EXP_A, 1'b0);

        load_default(8'h51);
        run_prog(0, 1'b0, 27, 400);
        repeat (2) tick();
        load_default(8'h51);
        run_prog(0, 1'b0, -1, 400);
        check_run("after_rst", 27, 59 + CS, 4 + CS, EXP_A, 1'b0);

        if (CS != 0) begin
            load_default(8'h50);
            run_prog(0, 1'b0, -1, 400);
            check_run("csum_bad", 27, 60, 5, EXP_A, 1'b1);
            load_default(8'h51);
            run_prog(0, 1'b0, -1, 400);
            check_run("csum_good", 27, 60, 5, EXP_A, 1'b0);
        end

        sel_b = 1'b1;
        src = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        if (CS != 0) src.push_back(8'h08);
        run_prog(0, 1'b0, -1, 600);
        check_run("param_b", 72, 154 + CS, 9 + CS, EXP_B, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
